// File: rtl/note_sequencer_pkg.sv
// Shared definitions for the note sequencer: FSM states, entry layout, byte lanes.
package note_sequencer_pkg;

  localparam int unsigned ENTRY_W = 32;

  // Byte k of an entry lands in lane 3-k: byte 0 is the most significant.
  localparam int unsigned BYTE_FREQ_HI = 0;
  localparam int unsigned BYTE_FREQ_LO = 1;
  localparam int unsigned BYTE_CTRL    = 2;
  localparam int unsigned BYTE_DUR     = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_NOTE  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // END flag sits at bit 7 of byte 2.
  typedef struct packed {
    logic [15:0] freq;
    logic        end_flag;
    logic [2:0]  rsvd;
    logic [3:0]  wave;
    logic [7:0]  dur;
  } entry_t;

  // One-hot byte enable for download byte k of an entry.
  function automatic logic [3:0] byte_lane(input logic [1:0] k);
    return 4'b1000 >> k;
  endfunction

endpackage

// File: rtl/note_sequencer_seq_ram.sv
// Sequence storage: DEPTH x 32-bit entries, byte-write port, registered read port.
module seq_ram
  import note_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic               CLK,
  input  logic               i_we,
  input  logic [3:0]         i_be,
  input  logic [ADDR_W-1:0]  i_waddr,
  input  logic [ENTRY_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0]  i_raddr,
  output logic [ENTRY_W-1:0] o_rdata
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [ENTRY_W-1:0] r_rdata;

  // Byte-enabled write and one-cycle-latency read; contents survive reset.
  always_ff @(posedge CLK) begin
    if (i_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/note_sequencer.sv
// Timed playback of a downloaded note sequence into one synth voice.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter  int unsigned DEPTH       = 64,
  parameter  int unsigned IOCTL_INDEX = 3,
  parameter  int unsigned TICK_DIV    = 240000,
  parameter  int unsigned GAP_TICKS   = 1,
  localparam int unsigned ADDR_W      = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [15:0]       tone_freq,
  output logic [3:0]        waveform_enable,
  output logic              gate,
  output logic              busy,
  output logic [ADDR_W-1:0] step
);

  localparam int unsigned      CNT_W      = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [24:0]      ADDR_LIMIT = 25'(4 * DEPTH);
  localparam logic [7:0]       GAP_LOAD   = 8'(GAP_TICKS);

  state_t             r_state;
  logic [ADDR_W-1:0]  r_step;
  logic [15:0]        r_tone;
  logic [3:0]         r_wave;
  logic               r_gate;
  logic [CNT_W-1:0]   r_cnt;
  logic [7:0]         r_remain;
  logic               r_end;

  logic               w_wr_acc;
  logic               w_abort;
  logic               w_tick;
  logic               w_end_sel;
  state_t             w_adv_state;
  logic [ADDR_W-1:0]  w_adv_step;
  logic [ENTRY_W-1:0] w_rdata;
  entry_t             w_entry;
  logic [2:0]         w_unused_rsvd;

  assign w_wr_acc = ioctl_wr && (ioctl_index == 8'(IOCTL_INDEX)) && (ioctl_addr < ADDR_LIMIT);
  // Rewriting the sequence under playback would play a half-updated entry, so it aborts like stop.
  assign w_abort  = stop || (w_wr_acc && (r_state != ST_IDLE));
  assign w_tick   = (r_cnt == CNT_LAST);

  seq_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .CLK     (CLK),
    .i_we    (w_wr_acc),
    .i_be    (byte_lane(ioctl_addr[1:0])),
    .i_waddr (ioctl_addr[ADDR_W+1:2]),
    .i_wdata ({4{ioctl_dout}}),
    .i_raddr (r_step),
    .o_rdata (w_rdata)
  );

  assign w_entry       = entry_t'(w_rdata);
  assign w_unused_rsvd = w_entry.rsvd;

  // Where to go once an entry is finished (or skipped): END flag comes live from RAM in LOAD.
  always_comb begin
    w_end_sel   = (r_state == ST_LOAD) ? w_entry.end_flag : r_end;
    w_adv_state = ST_FETCH;
    w_adv_step  = r_step + ADDR_W'(1);
    if (w_end_sel) begin
      if (loop_en) begin
        w_adv_step = '0;
      end else begin
        w_adv_state = ST_IDLE;
        w_adv_step  = r_step;
      end
    end
  end

  // Playback FSM with tempo tick counter; abort has priority over every state action.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_step   <= '0;
      r_tone   <= '0;
      r_wave   <= '0;
      r_gate   <= 1'b0;
      r_cnt    <= '0;
      r_remain <= '0;
      r_end    <= 1'b0;
    end else if (w_abort) begin
      r_state <= ST_IDLE;
      r_gate  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_FETCH;
            r_step  <= '0;
          end
        end
        ST_FETCH: r_state <= ST_LOAD;
        ST_LOAD: begin
          if (w_entry.dur == 8'd0) begin
            r_state <= w_adv_state;
            r_step  <= w_adv_step;
          end else begin
            r_tone   <= w_entry.freq;
            r_wave   <= w_entry.wave;
            r_gate   <= (w_entry.freq != 16'd0);
            r_cnt    <= '0;
            r_remain <= w_entry.dur;
            r_end    <= w_entry.end_flag;
            r_state  <= ST_NOTE;
          end
        end
        ST_NOTE: begin
          r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
          if (w_tick) begin
            if (r_remain == 8'd1) begin
              r_gate <= 1'b0;
              if (GAP_TICKS != 0) begin
                r_state  <= ST_GAP;
                r_remain <= GAP_LOAD;
              end else begin
                r_state <= w_adv_state;
                r_step  <= w_adv_step;
              end
            end else begin
              r_remain <= r_remain - 8'd1;
            end
          end
        end
        ST_GAP: begin
          r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
          if (w_tick) begin
            if (r_remain == 8'd1) begin
              r_state <= w_adv_state;
              r_step  <= w_adv_step;
            end else begin
              r_remain <= r_remain - 8'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tone_freq       = r_tone;
  assign waveform_enable = r_wave;
  assign gate            = r_gate;
  assign busy            = (r_state != ST_IDLE);
  assign step            = r_step;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed scenarios plus randomized sequences
// compared cycle by cycle against a timeline expanded from the playback rules.
module tb_note_sequencer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TD    = 4;
  localparam int unsigned GAP   = 1;
  localparam int unsigned IDX   = 3;

  logic        CLK = 1'b0;
  logic        rst;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic [15:0] tone_freq;
  logic [3:0]  waveform_enable;
  logic        gate;
  logic        busy;
  logic [2:0]  step;

  always #5 CLK = ~CLK;

  note_sequencer #(
    .DEPTH       (DEPTH),
    .IOCTL_INDEX (IDX),
    .TICK_DIV    (TD),
    .GAP_TICKS   (GAP)
  ) dut (
    .CLK             (CLK),
    .rst             (rst),
    .ioctl_wr        (ioctl_wr),
    .ioctl_index     (ioctl_index),
    .ioctl_addr      (ioctl_addr),
    .ioctl_dout      (ioctl_dout),
    .start           (start),
    .stop            (stop),
    .loop_en         (loop_en),
    .tone_freq       (tone_freq),
    .waveform_enable (waveform_enable),
    .gate            (gate),
    .busy            (busy),
    .step            (step)
  );

  typedef struct packed {
    logic [15:0] tone;
    logic [3:0]  wave;
    logic        gate;
    logic        busy;
    logic [2:0]  step;
  } obs_t;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] mem [DEPTH];   // shadow of the sequence RAM
  obs_t        m_now;         // outputs the model expects while idle
  obs_t        exp_q [$];

  function automatic obs_t mk(input logic [15:0] t, input logic [3:0] w, input logic g,
                              input logic b, input int s);
    obs_t o;
    o.tone = t; o.wave = w; o.gate = g; o.busy = b; o.step = 3'(s);
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(tone_freq, waveform_enable, gate, busy, int'(step));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic wr_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    int n;
    int k;
    ioctl_wr = 1'b1; ioctl_index = idx; ioctl_addr = a; ioctl_dout = d;
    @(posedge CLK); #1;
    ioctl_wr = 1'b0;
    if (idx == 8'(IDX) && a < 25'(4 * DEPTH)) begin
      n = int'(a >> 2);
      k = int'(a[1:0]);
      mem[n][8*(3-k) +: 8] = d;
    end
  endtask

  task automatic wr_entry(input int n, input logic [15:0] f, input logic [7:0] c, input logic [7:0] d);
    wr_byte(8'(IDX), 25'(4*n),     f[15:8]);
    wr_byte(8'(IDX), 25'(4*n + 1), f[7:0]);
    wr_byte(8'(IDX), 25'(4*n + 2), c);
    wr_byte(8'(IDX), 25'(4*n + 3), d);
  endtask

  // Expand the stored sequence into per-cycle expected outputs, starting the cycle after start.
  task automatic build(input int n, input logic lp);
    int          s;
    logic [15:0] t;
    logic [3:0]  w;
    logic [31:0] e;
    exp_q.delete();
    s = 0; t = m_now.tone; w = m_now.wave;
    while (exp_q.size() < n) begin
      e = mem[s];
      repeat (2) exp_q.push_back(mk(t, w, 1'b0, 1'b1, s));
      if (e[7:0] != 8'd0) begin
        t = e[31:16]; w = e[11:8];
        repeat (int'(e[7:0]) * TD) exp_q.push_back(mk(t, w, t != 16'd0, 1'b1, s));
        repeat (GAP * TD) exp_q.push_back(mk(t, w, 1'b0, 1'b1, s));
      end
      if (!e[15]) s = (s + 1) % DEPTH;
      else if (lp) s = 0;
      else while (exp_q.size() < n) exp_q.push_back(mk(t, w, 1'b0, 1'b0, s));
    end
  endtask

  // Play for up to n cycles, then end it at cycle 'at' with: 0 stop, 1 sequence write, 2 rst.
  task automatic play(input int n, input logic lp, input int kind, input int at,
                      input logic [4:0] wa, input logic [7:0] wd);
    obs_t want;
    int   last;
    last = (at > n - 1) ? n - 1 : at;
    build(n, lp);
    loop_en = lp;
    start = 1'b1; @(posedge CLK); #1; start = 1'b0;
    for (int i = 0; i <= last; i++) begin
      check("play", 32'(sample()), 32'(exp_q[i]));
      if (i < last) begin @(posedge CLK); #1; end
    end
    want = exp_q[last];
    want.gate = 1'b0;
    want.busy = 1'b0;
    case (kind)
      0: begin stop = 1'b1; @(posedge CLK); #1; stop = 1'b0; end
      1: wr_byte(8'(IDX), 25'(wa), wd);
      default: begin rst = 1'b1; @(posedge CLK); #1; rst = 1'b0; want = '0; end
    endcase
    check("abort", 32'(sample()), 32'(want));
    m_now = want;
    @(posedge CLK); #1;
    check("idle", 32'(sample()), 32'(want));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ioctl_wr = 1'b0; ioctl_index = '0; ioctl_addr = '0; ioctl_dout = '0;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    m_now = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset", 32'(sample()), 32'(obs_t'('0)));
    rst = 1'b0;
    for (int a = 0; a < int'(4 * DEPTH); a++) wr_byte(8'(IDX), 25'(a), 8'h00);
    check("idle_after_init", 32'(sample()), 32'(m_now));

    // Two-note sequence, single pass then looped, then stopped mid-note.
    wr_entry(0, 16'h1125, 8'h01, 8'h03);
    wr_entry(1, 16'h0B2F, 8'h84, 8'h02);
    play(40, 1'b0, 0, 39, '0, '0);
    play(70, 1'b1, 0, 69, '0, '0);
    play(20, 1'b0, 0, 6, '0, '0);

    // Start and stop together from idle: nothing starts.
    start = 1'b1; stop = 1'b1; @(posedge CLK); #1; start = 1'b0; stop = 1'b0;
    check("start_stop", 32'(sample()), 32'(m_now));
    @(posedge CLK); #1;
    check("start_stop_hold", 32'(sample()), 32'(m_now));

    // Zero-duration skip followed by a rest with END.
    wr_entry(0, 16'h1234, 8'h02, 8'h00);
    wr_entry(1, 16'h0000, 8'h81, 8'h02);
    play(30, 1'b0, 0, 29, '0, '0);

    // Out-of-range and wrong-index writes are ignored; a write while busy aborts.
    wr_entry(0, 16'h1125, 8'h01, 8'h03);
    wr_entry(1, 16'h0B2F, 8'h84, 8'h02);
    wr_byte(8'(IDX), 25'd32, 8'hFF);
    wr_byte(8'(IDX), 25'h100_0000, 8'hFF);
    wr_byte(8'd2, 25'd0, 8'hEE);
    play(40, 1'b0, 1, 8, 5'd0, 8'h22);
    play(40, 1'b0, 0, 39, '0, '0);

    // No END anywhere: step wraps; rst mid-note on the second pass.
    for (int n = 0; n < int'(DEPTH); n++) wr_entry(n, 16'(n + 1), 8'(n), 8'h01);
    play(100, 1'b0, 2, 84, '0, '0);

    // Randomized sequences, endings and abort points.
    for (int it = 0; it < 15; it++) begin
      for (int n = 0; n < int'(DEPTH); n++) begin
        logic [15:0] f;
        logic [7:0]  c;
        f = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
        c = {($urandom_range(0, 4) == 0), 3'b000, 4'($urandom)};
        wr_entry(n, f, c, 8'($urandom_range(0, 3)));
      end
      wr_byte(8'($urandom_range(0, 2)), 25'($urandom_range(0, 31)), 8'($urandom));
      wr_byte(8'(IDX), 25'($urandom_range(32, 200)), 8'($urandom));
      play(int'($urandom_range(20, 150)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
           int'($urandom_range(0, 160)), 5'($urandom), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
